i3c_bus_monitor: RTL

- Passive observer on the I3C bus lines that the i3c_wrapper drives (scl_o/sda_o) and samples (scl_i/sda_i).
- Synchronizes SCL/SDA, detects START, Repeated START and STOP, and deserializes 9-bit frames (8 data bits plus ACK/T).
- Reports bus-free/idle status.
- Instantiated next to the wrapper in simulation and usable in silicon as a bus-activity checker feeding error/interrupt logic.

---
 rtl/i3c_bus_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/i3c_bus_monitor.sv
// Passive I3C bus observer: synchronizes SCL/SDA, flags START / Repeated START / STOP,
// deserializes 9-bit frames and reports bus-idle status. Never drives the bus.
module i3c_bus_monitor #(
   parameter int unsigned SyncStages   = 2,
   parameter int unsigned IdleCycles   = 200,
   parameter int unsigned IdleCntWidth = $clog2(IdleCycles + 1)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       enable_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       start_det_o,
   output logic       rstart_det_o,
   output logic       stop_det_o,
   output logic       byte_valid_o,
   output logic [7:0] byte_o,
   output logic       ninth_bit_o,
   output logic       frame_err_o,
   output logic       bus_busy_o,
   output logic       bus_idle_o
);

   // byte_valid_o is a one-cycle strobe with no ready: byte_o/ninth_bit_o are valid
   // in the same cycle and hold until the next strobe, so a consumer must take it then.

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   localparam logic [IdleCntWidth-1:0] IdleMax = IdleCntWidth'(IdleCycles);

   logic [SyncStages-1:0]   scl_sync, sda_sync;
   logic                    scl_s, sda_s, scl_p, sda_p;
   logic                    scl_rise, start_ev, stop_ev;

   state_e                  state_q, state_d;
   logic [3:0]              bit_cnt_q, bit_cnt_d;
   logic [7:0]              shift_q, shift_d;
   logic [7:0]              byte_d;
   logic                    ninth_d;
   logic                    start_d, rstart_d, stop_d, valid_d, ferr_d;
   logic [IdleCntWidth-1:0] idle_cnt_q, idle_cnt_d;

   // Sync chains and previous-sample flops reset high so release never looks like an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_p    <= 1'b1;
         sda_p    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SyncStages-2:0], scl_i};
         sda_sync <= {sda_sync[SyncStages-2:0], sda_i};
         scl_p    <= scl_s;
         sda_p    <= sda_s;
      end
   end

   assign scl_s = scl_sync[SyncStages-1];
   assign sda_s = sda_sync[SyncStages-1];

   // An SCL rise wins over any simultaneous SDA change: it is a data sample.
   assign scl_rise = !scl_p && scl_s;
   assign start_ev = !scl_rise && scl_p && scl_s && sda_p && !sda_s;
   assign stop_ev  = !scl_rise && scl_p && scl_s && !sda_p && sda_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         idle_cnt_q   <= '0;
         byte_o       <= '0;
         ninth_bit_o  <= 1'b0;
         start_det_o  <= 1'b0;
         rstart_det_o <= 1'b0;
         stop_det_o   <= 1'b0;
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         idle_cnt_q   <= idle_cnt_d;
         byte_o       <= byte_d;
         ninth_bit_o  <= ninth_d;
         start_det_o  <= start_d;
         rstart_det_o <= rstart_d;
         stop_det_o   <= stop_d;
         byte_valid_o <= valid_d;
         frame_err_o  <= ferr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte_d     = byte_o;
      ninth_d    = ninth_bit_o;
      start_d    = 1'b0;
      rstart_d   = 1'b0;
      stop_d     = 1'b0;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      idle_cnt_d = '0;
      if (!enable_i) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_ev) begin
                  state_d   = ACTIVE;
                  start_d   = 1'b1;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end else if (scl_s && sda_s) begin
                  idle_cnt_d = (idle_cnt_q == IdleMax) ? IdleMax
                                                        : idle_cnt_q + IdleCntWidth'(1);
               end
            end
            ACTIVE: begin
               if (start_ev) begin
                  rstart_d  = 1'b1;
                  ferr_d    = (bit_cnt_q != 4'd0);
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end else if (stop_ev) begin
                  state_d   = IDLE;
                  stop_d    = 1'b1;
                  ferr_d    = (bit_cnt_q != 4'd0);
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end else if (scl_rise) begin
                  if (bit_cnt_q == 4'd8) begin
                     ninth_d   = sda_s;
                     byte_d    = shift_q;
                     valid_d   = 1'b1;
                     bit_cnt_d = '0;
                  end else begin
                     shift_d   = {shift_q[6:0], sda_s};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus_busy_o = (state_q == ACTIVE);
   assign bus_idle_o = (idle_cnt_q == IdleMax);

endmodule
